// File: rtl/otter_pl_fetch.sv
// OTTER pipelined fetch stage: PC register, next-PC select, IF/ID pipeline register.
// Define OTTER_FETCH_PERF_EN to add the FETCH_COUNT / SQUASH_COUNT performance counters.
module otter_pl_fetch #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [2:0]  PC_SOURCE,
   input  logic [31:0] JALR_TARGET,
   input  logic [31:0] BRANCH_TARGET,
   input  logic [31:0] JAL_TARGET,
   input  logic [31:0] MTVEC,
   input  logic [31:0] MEPC,
   input  logic        STALL,
   input  logic        FLUSH,
   output logic [31:0] IMEM_ADDR,
   output logic        IMEM_RDEN,
   input  logic [31:0] IMEM_DOUT,
   output logic [31:0] IFID_PC,
   output logic [31:0] IFID_PC4,
   output logic [31:0] IFID_IR,
   output logic        IFID_VALID
`ifdef OTTER_FETCH_PERF_EN
   ,
   output logic [31:0] FETCH_COUNT,
   output logic [31:0] SQUASH_COUNT
`endif
);

   typedef enum logic {BOOT, RUN} state_t;

   localparam logic [31:0] RESET_PC = {RESET_VEC[31:2], 2'b00};

   state_t      state, next_state;
   logic [31:0] pc, pc_plus4, target, next_pc;
   logic        redirect, advance, fetch_valid;

   // Next-PC select; sources 6-7 fall through to sequential fetch.
   always_comb begin
      pc_plus4 = pc + 32'd4;
      target   = pc_plus4;
      redirect = 1'b0;
      case (PC_SOURCE)
         3'd1:    begin target = JALR_TARGET;   redirect = 1'b1; end
         3'd2:    begin target = BRANCH_TARGET; redirect = 1'b1; end
         3'd3:    begin target = JAL_TARGET;    redirect = 1'b1; end
         3'd4:    begin target = MTVEC;         redirect = 1'b1; end
         3'd5:    begin target = MEPC;          redirect = 1'b1; end
         default: begin target = pc_plus4;      redirect = 1'b0; end
      endcase
      next_pc     = {target[31:2], 2'b00};
      fetch_valid = ~(redirect | FLUSH);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= BOOT;
      else     state <= next_state;
   end

   // Redirect and flush both override a stall, so the stage advances on any of them.
   always_comb begin
      next_state = state;
      IMEM_RDEN  = 1'b1;
      advance    = 1'b0;
      case (state)
         BOOT: next_state = RUN;
         RUN: begin
            IMEM_RDEN = ~STALL;
            advance   = redirect | FLUSH | ~STALL;
         end
         default: next_state = BOOT;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pc         <= RESET_PC;
         IFID_PC    <= 32'h0;
         IFID_PC4   <= 32'h0;
         IFID_VALID <= 1'b0;
      end else if (state == BOOT) begin
         pc         <= RESET_PC;
         IFID_VALID <= 1'b0;
      end else if (advance) begin
         pc         <= next_pc;
         IFID_PC    <= pc;
         IFID_PC4   <= pc_plus4;
         IFID_VALID <= fetch_valid;
      end
   end

`ifdef OTTER_FETCH_PERF_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         FETCH_COUNT  <= 32'h0;
         SQUASH_COUNT <= 32'h0;
      end else if (state == RUN && advance) begin
         if (fetch_valid) FETCH_COUNT  <= FETCH_COUNT + 32'd1;
         else             SQUASH_COUNT <= SQUASH_COUNT + 32'd1;
      end
   end
`endif

   // Synchronous IMEM output lines up with IF/ID because both sample the same PC on the same edge.
   assign IMEM_ADDR = pc;
   assign IFID_IR   = IFID_VALID ? IMEM_DOUT : NOP_INSTR;

endmodule

// File: doc/otter_pl_fetch.md
OTTER_PL_FETCH -- requirements
Module: otter_pl_fetch

Interface
REQ-001 Parameter RESET_VEC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), instruction presented when IF/ID is invalid.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 PC_SOURCE  in  3  next-PC select from decode: 0 PC+4, 1 JALR, 2 BRANCH, 3 JAL, 4 MTVEC (interrupt), 5 MEPC (mret), 6-7 PC+4.
REQ-006 JALR_TARGET, BRANCH_TARGET, JAL_TARGET, MTVEC, MEPC  in  32 each  redirect targets.
REQ-007 STALL  in  1  hazard stall; hold PC and IF/ID.
REQ-008 FLUSH  in  1  squash the instruction entering IF/ID.
REQ-009 IMEM_ADDR  out  32  instruction memory address (= PC).
REQ-010 IMEM_RDEN  out  1  instruction memory read enable (MEM_READ_1).
REQ-011 IMEM_DOUT  in  32  instruction memory data; synchronous read, valid one cycle after IMEM_RDEN sampled high.
REQ-012 IFID_PC, IFID_PC4  out  32 each  PC and PC+4 of the instruction in IF/ID.
REQ-013 IFID_IR  out  32  instruction in IF/ID.
REQ-014 IFID_VALID  out  1  IF/ID holds a real instruction.

Function
REQ-015 FSM states: BOOT, RUN; RST forces BOOT; BOOT moves to RUN unconditionally on the next edge.
REQ-016 In BOOT, PC shall hold RESET_VEC, IMEM_RDEN=1, and IFID_VALID shall be loaded 0.
REQ-017 IMEM_ADDR shall equal the PC register combinationally; bits [1:0] of every loaded PC shall be forced to 2'b00.
REQ-018 IMEM_RDEN shall be the inverse of STALL in RUN, so memory output holds during stall.
REQ-019 In RUN with STALL=0, each edge shall load IFID_PC<=PC, IFID_PC4<=PC+4, IFID_VALID<=1, PC<=next-PC per REQ-005.
REQ-020 PC+4 arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 32'h0.
REQ-021 PC_SOURCE in 1..5 is a redirect: PC loads the target and IFID_VALID loads 0 (wrong-path fetch squashed) on that edge.
REQ-022 FLUSH=1 shall load IFID_VALID<=0; PC advances per REQ-019/021.
REQ-023 STALL=1 with no redirect and no FLUSH: PC, IFID_PC, IFID_PC4, IFID_VALID unchanged.
REQ-024 Priority: redirect > FLUSH > STALL; redirect during STALL loads target and clears IFID_VALID.
REQ-025 IFID_IR shall be IMEM_DOUT when IFID_VALID=1, else NOP_INSTR.
REQ-026 Fetch-to-IF/ID latency is one cycle; sustained throughput one instruction per cycle without stalls/redirects.

Reset
REQ-027 On RST assertion, immediately: PC=RESET_VEC, IFID_PC=0, IFID_PC4=0, IFID_VALID=0, state=BOOT, counters=0.
REQ-028 RST asserted mid-stall or mid-redirect discards all in-flight state; first valid instruction follows RST release by two edges.

Configuration
REQ-029 Macro OTTER_FETCH_PERF_EN defined: add outputs FETCH_COUNT (32) and SQUASH_COUNT (32).
REQ-030 FETCH_COUNT increments each edge IFID_VALID loads 1; SQUASH_COUNT increments each edge a redirect or FLUSH clears it (once per edge); both wrap modulo 2^32.
REQ-031 Macro undefined: counter ports and logic absent; all other behaviour identical.

Verification
REQ-032 Reset release, PC_SOURCE=0, no stall -> IMEM_ADDR 0,4,8,...; IFID_VALID rises second edge with IFID_PC=0, IFID_PC4=4.
REQ-033 PC_SOURCE=3, JAL_TARGET=32'h100 at PC=8 -> next IMEM_ADDR 32'h100, IFID_VALID 0 one cycle, IFID_IR=32'h0000_0013, then IFID_PC=32'h100.
REQ-034 STALL=1 for 3 cycles at PC=32'h20 -> IMEM_RDEN=0, IMEM_ADDR and IFID_* constant 3 cycles; resumes with 32'h24.
REQ-035 STALL=1 and PC_SOURCE=4, MTVEC=32'h200 same cycle -> PC=32'h200, IFID_VALID=0; JALR_TARGET=32'h303 -> PC=32'h300.
REQ-036 PC=32'hFFFF_FFFC, PC_SOURCE=0 -> next PC 32'h0; RST pulsed mid-run -> outputs reset values immediately, no clock edge needed.
REQ-037 With OTTER_FETCH_PERF_EN: 10 sequential fetches then 2 redirects -> FETCH_COUNT=10, SQUASH_COUNT=2.
